pll_dps_responder: RTL and testbench
====================================

PLL_DPS_RESPONDER -- requirements
Module: pll_dps_responder

Interface
REQ-001 The block SHALL have parameter PHASE_MOD, default 64: phase positions per VCO period; legal range 2..256.
REQ-002 The block SHALL have parameter DONE_DELAY, default 2: scanclk rising edges phasedone stays low per step.
REQ-003 The block SHALL have parameter CLKSW_MIN, default 4: minimum clkswitch high time, in clk cycles, to count as a switch request.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port phasecounterselect, input, 3 bits: 000 all, 001 M, 010 C0, 011 C1, 100 C2, 101 C3, 110 C4, 111 invalid.
REQ-007 The block SHALL have port phaseupdown, input, 1 bit: 1 advances the phase, 0 retards it.
REQ-008 The block SHALL have port phasestep, input, 1 bit: step request, sampled on scanclk rising edges.
REQ-009 The block SHALL have port scanclk, input, 1 bit: a slow clock-enable-style input, edge-detected in the clk domain.
REQ-010 The block SHALL have port clkswitch, input, 1 bit: clock-input toggle request.
REQ-011 The block SHALL have port phasedone, output, 1 bit: low while a step is in progress.
REQ-012 The block SHALL have port activeclock, output, 1 bit: 0 means inclk0 is active, 1 means inclk1 is active.
REQ-013 The block SHALL have port phase_offsets, output, 48 bits: six 8-bit unsigned offsets; M is in [7:0], then C0..C4 ascending.
REQ-014 The block SHALL have port step_count, output, 16 bits: count of completed steps.
REQ-015 The block SHALL have port sel_error, output, 1 bit: sticky flag for an invalid select or a short phasestep.

Function
REQ-016 A scanclk rise SHALL be detected as scanclk high while its registered copy is low; decisions SHALL be made in that same clk cycle.
REQ-017 The FSM SHALL have states IDLE, ARMED, BUSY and RELEASE, and SHALL reset to IDLE.
REQ-018 In IDLE, phasestep high at a scanclk rise SHALL move the FSM to ARMED.
REQ-019 In ARMED, phasestep high at the next scanclk rise SHALL latch phasecounterselect and phaseupdown, move the FSM to BUSY, and drive phasedone low on the following clk.
REQ-020 In ARMED, phasestep low at that scanclk rise SHALL return the FSM to IDLE with no step and set sel_error.
REQ-021 In BUSY, after DONE_DELAY scanclk rises, the block SHALL apply the step and raise phasedone in the same clk edge, then move to RELEASE.
REQ-022 In RELEASE, the FSM SHALL return to IDLE only at a scanclk rise with phasestep low, so each assertion yields exactly one step.
REQ-023 Step up SHALL compute offset = (offset==PHASE_MOD-1) ? 0 : offset+1; step down SHALL compute offset = (offset==0) ? PHASE_MOD-1 : offset-1.
REQ-024 Select 000 SHALL update all six offsets in the same cycle.
REQ-025 Select 111 SHALL leave the offsets unchanged, set sel_error, and still complete the phasedone handshake.
REQ-026 Changes to phasecounterselect or phaseupdown after the latch in REQ-019 SHALL be ignored until the next step.
REQ-027 clkswitch is edge-processed: a high run of at least CLKSW_MIN clk cycles SHALL toggle activeclock on the falling edge of clkswitch; shorter runs SHALL be ignored.
REQ-028 clkswitch handling and phase steps SHALL be independent and SHALL both act when they coincide.

Reset
REQ-029 When rst is high at a clk edge, the FSM SHALL be IDLE, phasedone 1, activeclock 0, all offsets 0, step_count 0, sel_error 0, and the scanclk and clkswitch trackers cleared.
REQ-030 A reset in the middle of a step SHALL abort the step with no offset change; phasestep still high after reset SHALL need two fresh scanclk rises to step.

Configuration
REQ-031 With macro PLL_DPS_STATS_EN defined, step_count SHALL increment saturating at 16'hFFFF on each applied step, and sel_error SHALL be live.
REQ-032 Without PLL_DPS_STATS_EN, step_count and sel_error SHALL be tied to 0 and no statistics registers SHALL be built.

Structure
REQ-033 Shared package pll_dps_pkg SHALL hold the FSM state enum, the select codes (SEL_ALL, SEL_M, SEL_C0..SEL_C4, SEL_INVALID), and the offset field width and index constants.
REQ-034 A single sub-module, pll_clkswitch_det, SHALL contain the clkswitch run-length counter and the activeclock toggle.

Verification
REQ-035 Bench: select 011, updown 1, phasestep held for 3 scanclk periods -> C1 offset 0 to 1, other offsets 0, one phasedone low pulse of 2 scanclk rises, step_count 1.
REQ-036 Bench: select 000, updown 0, from reset -> all six offsets 63 (PHASE_MOD 64).
REQ-037 Bench: select 111 step -> offsets unchanged, sel_error 1, phasedone pulses normally.
REQ-038 Bench: phasestep high for only one scanclk rise -> no offset change, sel_error 1, phasedone stays 1.
REQ-039 Bench: clkswitch high for 3 clk, then for 8 clk -> activeclock stays 0 after the first pulse, becomes 1 after the second falls.
REQ-040 Bench: rst asserted while in BUSY -> offsets 0, phasedone 1 on the next clk; phasestep still high gives no step until two new scanclk rises.

Source files
------------

// File: rtl/pll_dps_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift responder:
// FSM states, counter select codes, offset field layout.
package pll_dps_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    BUSY,
    RELEASE
  } dps_state_e;

  localparam logic [2:0] SEL_ALL     = 3'b000;
  localparam logic [2:0] SEL_M       = 3'b001;
  localparam logic [2:0] SEL_C0      = 3'b010;
  localparam logic [2:0] SEL_C1      = 3'b011;
  localparam logic [2:0] SEL_C2      = 3'b100;
  localparam logic [2:0] SEL_C3      = 3'b101;
  localparam logic [2:0] SEL_C4      = 3'b110;
  localparam logic [2:0] SEL_INVALID = 3'b111;

  localparam int OFS_W   = 8;
  localparam int NUM_OFS = 6;
  localparam int IDX_M   = 0;
  localparam int IDX_C0  = 1;
  localparam int IDX_C1  = 2;
  localparam int IDX_C2  = 3;
  localparam int IDX_C3  = 4;
  localparam int IDX_C4  = 5;

  // Offset idx is addressed by select code idx+1, or by SEL_ALL.
  function automatic logic sel_hits(
    input logic [2:0] sel,
    input int         idx
  );
    return (sel == SEL_ALL) || (sel == 3'(idx + 1));
  endfunction

endpackage

// File: rtl/pll_clkswitch_det.sv
// clkswitch run-length filter: toggles activeclock on the falling edge of
// a clkswitch high run lasting at least CLKSW_MIN clk cycles.
// Ports: clk, rst (sync, active-high), clkswitch in, activeclock out.
module pll_clkswitch_det #(
  parameter int CLKSW_MIN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clkswitch,
  output logic activeclock
);

  localparam int CW = $clog2(CLKSW_MIN + 1);

  logic [CW-1:0] run_q;
  logic          sw_q;
  logic          act_q;
  logic          fall;
  logic          long_run;

  assign fall     = sw_q & ~clkswitch;
  // run_q saturates at CLKSW_MIN, so it still holds the qualified
  // length in the cycle the fall is seen.
  assign long_run = (run_q >= CW'(CLKSW_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      sw_q  <= 1'b0;
      act_q <= 1'b0;
    end else begin
      sw_q <= clkswitch;
      if (clkswitch) begin
        if (!long_run) run_q <= run_q + 1'b1;
      end else begin
        run_q <= '0;
      end
      if (fall && long_run) act_q <= ~act_q;
    end
  end

  assign activeclock = act_q;

endmodule

// File: rtl/pll_dps_responder.sv
// PLL dynamic phase-shift responder: phasestep/phasedone handshake on
// scanclk rises, six wrapping phase offsets, clkswitch toggle.
// Ports: clk, rst, phasecounterselect, phaseupdown, phasestep, scanclk,
// clkswitch in; phasedone, activeclock, phase_offsets, step_count,
// sel_error out. PLL_DPS_STATS_EN builds step_count/sel_error.
module pll_dps_responder
  import pll_dps_pkg::*;
#(
  parameter int PHASE_MOD  = 64,
  parameter int DONE_DELAY = 2,
  parameter int CLKSW_MIN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  phasecounterselect,
  input  logic        phaseupdown,
  input  logic        phasestep,
  input  logic        scanclk,
  input  logic        clkswitch,
  output logic        phasedone,
  output logic        activeclock,
  output logic [47:0] phase_offsets,
  output logic [15:0] step_count,
  output logic        sel_error
);

  localparam int DW = (DONE_DELAY > 1) ? $clog2(DONE_DELAY) : 1;
  localparam logic [OFS_W-1:0] TOP = OFS_W'(PHASE_MOD - 1);

  dps_state_e       state_q, state_d;
  logic             scan_q;
  logic             scan_rise;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [2:0]       sel_q;
  logic             up_q;
  logic             done_q, done_d;
  logic             latch;
  logic             apply;
  logic [OFS_W-1:0] off_q [NUM_OFS];

  function automatic logic [OFS_W-1:0] step_ofs(
    input logic [OFS_W-1:0] v,
    input logic             up
  );
    if (up) return (v == TOP) ? '0 : v + 1'b1;
    return (v == '0) ? TOP : v - 1'b1;
  endfunction

  assign scan_rise = scanclk & ~scan_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    latch   = 1'b0;
    apply   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_rise && phasestep) state_d = ARMED;
      end
      ARMED: begin
        if (scan_rise) begin
          if (phasestep) begin
            latch   = 1'b1;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BUSY: begin
        if (scan_rise) begin
          if (cnt_q == DW'(DONE_DELAY - 1)) begin
            apply   = 1'b1;
            done_d  = 1'b1;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        if (scan_rise && !phasestep) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scan_q  <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= SEL_ALL;
      up_q    <= 1'b0;
      done_q  <= 1'b1;
      for (int i = 0; i < NUM_OFS; i++) off_q[i] <= '0;
    end else begin
      state_q <= state_d;
      scan_q  <= scanclk;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (latch) begin
        sel_q <= phasecounterselect;
        up_q  <= phaseupdown;
      end
      if (apply && sel_q != SEL_INVALID) begin
        for (int i = 0; i < NUM_OFS; i++) begin
          if (sel_hits(sel_q, i)) off_q[i] <= step_ofs(off_q[i], up_q);
        end
      end
    end
  end

  assign phasedone = done_q;

  for (genvar g = 0; g < NUM_OFS; g++) begin : g_ofs
    assign phase_offsets[g*OFS_W +: OFS_W] = off_q[g];
  end

`ifdef PLL_DPS_STATS_EN
  logic [15:0] count_q;
  logic        err_q;
  logic        step_ok;
  logic        bad;

  assign step_ok = apply && (sel_q != SEL_INVALID);
  // Short phasestep (dropped before the second rise) or invalid select.
  assign bad = ((state_q == ARMED) && scan_rise && !phasestep)
            || (latch && phasecounterselect == SEL_INVALID);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (step_ok && count_q != 16'hFFFF) count_q <= count_q + 1'b1;
      if (bad) err_q <= 1'b1;
    end
  end

  assign step_count = count_q;
  assign sel_error  = err_q;
`else
  assign step_count = '0;
  assign sel_error  = 1'b0;
`endif

  pll_clkswitch_det #(
    .CLKSW_MIN(CLKSW_MIN)
  ) u_clksw (
    .clk        (clk),
    .rst        (rst),
    .clkswitch  (clkswitch),
    .activeclock(activeclock)
  );

endmodule

// File: tb/tb_pll_dps_responder.sv
// Self-checking bench for pll_dps_responder: directed handshake, wrap,
// invalid/short step, clkswitch and reset cases, then randomized steps.
module tb_pll_dps_responder;

  localparam int PM  = 64;
  localparam int DD  = 2;
  localparam int CSM = 4;
  localparam int SP  = 8;
`ifdef PLL_DPS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  phasecounterselect = 3'd0;
  logic        phaseupdown = 1'b0;
  logic        phasestep = 1'b0;
  logic        scanclk = 1'b0;
  logic        clkswitch = 1'b0;
  logic        phasedone;
  logic        activeclock;
  logic [47:0] phase_offsets;
  logic [15:0] step_count;
  logic        sel_error;

  always #5 clk = ~clk;

  pll_dps_responder #(
    .PHASE_MOD (PM),
    .DONE_DELAY(DD),
    .CLKSW_MIN (CSM)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .phasecounterselect(phasecounterselect),
    .phaseupdown       (phaseupdown),
    .phasestep         (phasestep),
    .scanclk           (scanclk),
    .clkswitch         (clkswitch),
    .phasedone         (phasedone),
    .activeclock       (activeclock),
    .phase_offsets     (phase_offsets),
    .step_count        (step_count),
    .sel_error         (sel_error)
  );

  int vectors = 0;
  int miscompares = 0;

  int m_off [6];
  bit m_act;
  bit m_err;
  int m_cnt;

  int   pulses = 0;
  int   low_clks = 0;
  logic pd_prev = 1'b1;

  always @(negedge clk) begin
    if (phasedone === 1'b0) low_clks++;
    if (pd_prev === 1'b1 && phasedone === 1'b0) pulses++;
    pd_prev = phasedone;
  end

  task automatic check(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] m_pack();
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = 8'(m_off[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_off[i] = 0;
    m_act = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_apply(input int sel, input bit up);
    if (sel == 7) begin
      m_err = 1'b1;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sel == 0 || sel == i + 1)
          m_off[i] = up ? (m_off[i] + 1) % PM : (m_off[i] + PM - 1) % PM;
      end
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/offsets"}, phase_offsets, m_pack());
    check({tag, "/activeclock"}, 48'(activeclock), 48'(m_act));
    check({tag, "/phasedone"}, 48'(phasedone), 48'(1));
    check({tag, "/sel_error"}, 48'(sel_error), 48'(STATS ? m_err : 1'b0));
    check({tag, "/step_count"}, 48'(step_count),
          48'(STATS ? m_cnt : 0));
  endtask

  // One scanclk period; clkswitch high for the first sw clk cycles.
  task automatic scan_period(input int sw);
    for (int c = 0; c < SP; c++) begin
      scanclk   = (c < SP / 2);
      clkswitch = (c < sw);
      @(negedge clk);
    end
    scanclk   = 1'b0;
    clkswitch = 1'b0;
    if (sw >= CSM) m_act = ~m_act;
  endtask

  task automatic full_step(input logic [2:0] sel, input bit up,
                           input int sw, input bit scramble,
                           input string tag);
    int p0;
    int l0;
    p0 = pulses;
    l0 = low_clks;
    phasecounterselect = sel;
    phaseupdown = up;
    phasestep = 1'b1;
    scan_period(sw);
    scan_period(0);
    if (scramble) begin
      phasecounterselect = 3'($urandom_range(0, 7));
      phaseupdown = ~up;
    end
    scan_period(0);
    phasestep = 1'b0;
    repeat (DD + 1) scan_period(0);
    model_apply(int'(sel), up);
    check({tag, "/pd_pulses"}, 48'(pulses - p0), 48'(1));
    check({tag, "/pd_low_clks"}, 48'(low_clks - l0), 48'(DD * SP));
    check_all(tag);
  endtask

  task automatic short_step(input int sw, input string tag);
    int p0;
    p0 = pulses;
    phasestep = 1'b1;
    scan_period(sw);
    phasestep = 1'b0;
    scan_period(0);
    scan_period(0);
    m_err = 1'b1;
    check({tag, "/pd_pulses"}, 48'(pulses - p0), 48'(0));
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_all(tag);
    rst = 1'b0;
  endtask

  task automatic sw_pulse(input int len);
    clkswitch = 1'b1;
    repeat (len) @(negedge clk);
    clkswitch = 1'b0;
    repeat (2) @(negedge clk);
    if (len >= CSM) m_act = ~m_act;
    check($sformatf("clksw_%0d", len), 48'(activeclock), 48'(m_act));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("por");
    rst = 1'b0;
    @(negedge clk);

    full_step(3'b011, 1'b1, 0, 1'b0, "c1_up");
    do_reset("rst1");
    full_step(3'b000, 1'b0, 0, 1'b0, "all_down");
    full_step(3'b111, 1'b1, 0, 1'b0, "invalid");
    short_step(0, "short");
    sw_pulse(3);
    sw_pulse(8);

    full_step(3'b001, 1'b1, 5, 1'b0, "m_up_sw");
    phasecounterselect = 3'b100;
    phaseupdown = 1'b1;
    phasestep = 1'b1;
    scan_period(0);
    scan_period(0);
    scan_period(0);
    check("busy_pd_low", 48'(phasedone), 48'(0));
    do_reset("rst_busy");
    scan_period(0);
    check("rst_1rise_pd", 48'(phasedone), 48'(1));
    check("rst_1rise_ofs", phase_offsets, m_pack());
    scan_period(0);
    check("rst_2rise_pd", 48'(phasedone), 48'(0));
    phasestep = 1'b0;
    repeat (DD + 1) scan_period(0);
    model_apply(4, 1'b1);
    check_all("rst_restep");

    for (int n = 0; n < 24; n++) begin
      int kind;
      int sw;
      kind = $urandom_range(0, 4);
      sw = $urandom_range(0, 7);
      if (kind == 4)
        short_step(sw, "rand_short");
      else
        full_step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  sw, 1'b1, "rand_step");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
